led_matrix_scan: RTL and testbench

Reads the 64x64 monochrome Pong framebuffer, one row pair at a time, and drives a HUB75 1/32-scan LED panel. It is the panel-side consumer of the framebuffer that the game's frame composer fills with ball, paddles, score digits and centre line. It also issues a one-cycle frame marker so game logic can time its updates against the refresh.

---
 rtl/led_matrix_pkg.sv | 19 +
 rtl/hub75_serializer.sv | 63 ++++++
 rtl/led_matrix_scan.sv | 130 +++++++++++++
 tb/tb_led_matrix_scan.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared constants and types for the HUB75 LED matrix scan path.
package led_matrix_pkg;

    localparam int COLS      = 64;
    localparam int ROWS      = 64;
    localparam int SCAN_ROWS = ROWS / 2;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY
    } state_t;

    typedef logic [2:0] color_t;

endpackage

// File: rtl/hub75_serializer.sv
// Holds one row pair and shifts it out column by column with a divided hub_clk.
module hub75_serializer
    import led_matrix_pkg::*;
#(
    parameter int     COLS     = 64,
    parameter int     CLK_DIV  = 2,
    parameter color_t ON_COLOR = 3'b010
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_top,
    input  logic            load_bot,
    input  logic [COLS-1:0] data,
    input  logic            run,
    output logic            hub_clk,
    output color_t          rgb1,
    output color_t          rgb2,
    output logic            done
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DW = $clog2(CLK_DIV + 1);

    logic [COLS-1:0] top;
    logic [COLS-1:0] bot;
    logic [CW-1:0]   col;
    logic [DW-1:0]   div;
    logic            phase;
    logic            div_end;

    assign div_end = (div == DW'(CLK_DIV - 1));

    // phase 0 is the low half of hub_clk, phase 1 the high half; a column ends on the high half
    always_ff @(posedge clk) begin
        if (rst) begin
            top   <= '0;
            bot   <= '0;
            col   <= '0;
            div   <= '0;
            phase <= 1'b0;
        end else begin
            if (load_top) top <= data;
            if (load_bot) bot <= data;
            if (!run) begin
                col   <= '0;
                div   <= '0;
                phase <= 1'b0;
            end else if (div_end) begin
                div   <= '0;
                phase <= ~phase;
                if (phase) col <= col + 1'b1;
            end else begin
                div <= div + 1'b1;
            end
        end
    end

    assign hub_clk = run & phase;
    assign rgb1    = run ? (ON_COLOR & {3{top[col]}}) : '0;
    assign rgb2    = run ? (ON_COLOR & {3{bot[col]}}) : '0;
    assign done    = run & phase & div_end & (col == CW'(COLS - 1));

endmodule

// File: rtl/led_matrix_scan.sv
// HUB75 1/32-scan driver: fetches row pairs from the Pong framebuffer and refreshes the panel.
module led_matrix_scan
    import led_matrix_pkg::*;
#(
    parameter int     COLS      = led_matrix_pkg::COLS,
    parameter int     ROWS      = led_matrix_pkg::ROWS,
    parameter int     CLK_DIV   = 2,
    parameter int     ON_CYCLES = 256,
    parameter color_t ON_COLOR  = 3'b010
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    output logic            fb_rd,
    output logic [5:0]      fb_addr,
    input  logic [COLS-1:0] fb_data,
    output logic            hub_r1,
    output logic            hub_g1,
    output logic            hub_b1,
    output logic            hub_r2,
    output logic            hub_g2,
    output logic            hub_b2,
    output logic [4:0]      hub_addr,
    output logic            hub_clk,
    output logic            hub_lat,
    output logic            hub_oe_n,
    output logic            frame_start
);

    localparam int SCAN = ROWS / 2;
    localparam int LW   = $clog2(CLK_DIV + 1);
    localparam int OW   = $clog2(ON_CYCLES + 1);

    state_t        state;
    logic [1:0]    fph;
    logic [4:0]    scan_row;
    logic [LW-1:0] lat_cnt;
    logic [OW-1:0] on_cnt;
    logic          ser_done;
    color_t        rgb1;
    color_t        rgb2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fph      <= '0;
            scan_row <= '0;
            lat_cnt  <= '0;
            on_cnt   <= '0;
            hub_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= FETCH;
                        fph   <= '0;
                    end
                end
                FETCH: begin
                    if (fph == 2'd2) begin
                        state <= SHIFT;
                        fph   <= '0;
                    end else begin
                        fph <= fph + 1'b1;
                    end
                end
                SHIFT: begin
                    if (ser_done) state <= BLANK;
                end
                BLANK: begin
                    hub_addr <= scan_row;
                    lat_cnt  <= '0;
                    state    <= LATCH;
                end
                LATCH: begin
                    if (lat_cnt == LW'(CLK_DIV - 1)) begin
                        on_cnt <= '0;
                        state  <= DISPLAY;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                DISPLAY: begin
                    // enable is only honoured here, so a row that has started always completes
                    if (on_cnt == OW'(ON_CYCLES - 1)) begin
                        scan_row <= (scan_row == 5'(SCAN - 1)) ? '0 : scan_row + 1'b1;
                        state    <= enable ? FETCH : IDLE;
                    end else begin
                        on_cnt <= on_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        fb_rd   = 1'b0;
        fb_addr = '0;
        if (state == FETCH && fph != 2'd2) begin
            fb_rd   = 1'b1;
            fb_addr = (fph == 2'd0) ? {1'b0, scan_row} : {1'b0, scan_row} + 6'(SCAN);
        end
    end

    assign frame_start = (state == FETCH) && (fph == 2'd0) && (scan_row == 5'd0);
    assign hub_lat     = (state == LATCH);
    assign hub_oe_n    = (state != DISPLAY);

    hub75_serializer #(
        .COLS    (COLS),
        .CLK_DIV (CLK_DIV),
        .ON_COLOR(ON_COLOR)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load_top(state == FETCH && fph == 2'd1),
        .load_bot(state == FETCH && fph == 2'd2),
        .data    (fb_data),
        .run     (state == SHIFT),
        .hub_clk (hub_clk),
        .rgb1    (rgb1),
        .rgb2    (rgb2),
        .done    (ser_done)
    );

    assign {hub_r1, hub_g1, hub_b1} = rgb1;
    assign {hub_r2, hub_g2, hub_b2} = rgb2;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Bench for led_matrix_scan: row-timeline reference model plus directed timing checks.
`timescale 1ns/1ps
module tb_led_matrix_scan;

    localparam int NC      = 64;
    localparam int CD      = 2;
    localparam int ON      = 256;
    localparam logic [2:0] COLOR = 3'b010;
    localparam int SL      = 2 * NC * CD;
    localparam int T_BLANK = 3 + SL;
    localparam int T_LAT   = T_BLANK + 1;
    localparam int T_DISP  = T_LAT + CD;
    localparam int ROW_LEN = T_DISP + ON;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          fb_rd;
    logic [5:0]    fb_addr;
    logic [NC-1:0] fb_data = '0;
    logic          hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2;
    logic [4:0]    hub_addr;
    logic          hub_clk, hub_lat, hub_oe_n, frame_start;

    logic [63:0] mem [64];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_on  = 1'b0;

    bit m_run   = 1'b0;
    int m_row   = 0;
    int m_t     = 0;
    int m_haddr = 0;

    led_matrix_scan #(
        .COLS     (NC),
        .ROWS     (64),
        .CLK_DIV  (CD),
        .ON_CYCLES(ON),
        .ON_COLOR (COLOR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fb_rd      (fb_rd),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .hub_r1     (hub_r1),
        .hub_g1     (hub_g1),
        .hub_b1     (hub_b1),
        .hub_r2     (hub_r2),
        .hub_g2     (hub_g2),
        .hub_b2     (hub_b2),
        .hub_addr   (hub_addr),
        .hub_clk    (hub_clk),
        .hub_lat    (hub_lat),
        .hub_oe_n   (hub_oe_n),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fb_rd) fb_data <= mem[fb_addr];
    end

    // Reference: a row is a fixed timeline of ROW_LEN cycles; t is the position in it
    always @(posedge clk) begin
        if (rst) begin
            m_run <= 1'b0; m_row <= 0; m_t <= 0; m_haddr <= 0;
        end else if (!m_run) begin
            if (enable) begin m_run <= 1'b1; m_t <= 0; end
        end else begin
            if (m_t == T_BLANK) m_haddr <= m_row;
            if (m_t == ROW_LEN - 1) begin
                m_t <= 0; m_row <= (m_row + 1) % 32; m_run <= enable;
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    function automatic logic [21:0] expect_out(bit run, int row, int t, int haddr);
        logic rd = 1'b0, hc = 1'b0, lat = 1'b0, oe = 1'b1, fs = 1'b0;
        logic [5:0] addr = '0;
        logic [2:0] c1 = '0, c2 = '0;
        if (run) begin
            if (t == 0) begin rd = 1'b1; addr = 6'(row); fs = (row == 0); end
            if (t == 1) begin rd = 1'b1; addr = 6'(row + 32); end
            if (t >= 3 && t < 3 + SL) begin
                int k = t - 3;
                int c = k / (2 * CD);
                hc = ((k % (2 * CD)) >= CD);
                c1 = mem[row][c]      ? COLOR : 3'b000;
                c2 = mem[row + 32][c] ? COLOR : 3'b000;
            end
            if (t >= T_LAT && t < T_DISP) lat = 1'b1;
            if (t >= T_DISP) oe = 1'b0;
        end
        return {rd, addr, c1, c2, 5'(haddr), hc, lat, oe, fs};
    endfunction

    wire [21:0] outs = {fb_rd, fb_addr, hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2,
                        hub_addr, hub_clk, hub_lat, hub_oe_n, frame_start};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) chk("outputs", 64'(outs), 64'(expect_out(m_run, m_row, m_t, m_haddr)));
    end

    task automatic wait_f0(input int row, input int limit);
        int n = 0;
        while (!(fb_rd && fb_addr == 6'(row) && row < 32) && n < limit) begin
            @(negedge clk); n++;
        end
        chk($sformatf("reach_row_%0d", row), 64'(n < limit), 64'd1);
    endtask

    initial begin
        int rises, g1_n, g1_at, g2_n, g2_at, lat_n, lat_first, oe_low, n, cyc0, steps;
        logic prev_clk;
        logic [4:0] prev_haddr;

        for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};
        mem[0]  = 64'h1;
        mem[32] = 64'h8000_0000_0000_0000;

        repeat (3) @(posedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        chk("reset_oe_n", 64'(hub_oe_n), 64'd1);
        chk("reset_others", 64'(outs & 22'h3ffffd), 64'd0);

        enable = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("first_frame_start", 64'(frame_start), 64'd1);
        chk("first_fetch_addr", 64'({fb_rd, fb_addr}), 64'({1'b1, 6'd0}));
        cyc0 = cyc;

        rises = 0; g1_n = 0; g1_at = 0; g2_n = 0; g2_at = 0;
        lat_n = 0; lat_first = -1; oe_low = 0; prev_clk = 1'b0;
        for (int t = 0; t < ROW_LEN; t++) begin
            if (t == 1) chk("second_fetch_addr", 64'({fb_rd, fb_addr}), 64'({1'b1, 6'd32}));
            if (hub_clk && !prev_clk) begin
                rises++;
                if (hub_g1) begin g1_n++; g1_at = rises; end
                if (hub_g2) begin g2_n++; g2_at = rises; end
            end
            prev_clk = hub_clk;
            if (hub_lat) begin lat_n++; if (lat_first < 0) lat_first = t; end
            if (!hub_oe_n) oe_low++;
            @(negedge clk);
        end
        chk("next_fetch_518", 64'({fb_rd, fb_addr}), 64'({1'b1, 6'd1}));
        chk("clk_rises", 64'(rises), 64'd64);
        chk("g1_rise_count", 64'(g1_n), 64'd1);
        chk("g1_rise_index", 64'(g1_at), 64'd1);
        chk("g2_rise_count", 64'(g2_n), 64'd1);
        chk("g2_rise_index", 64'(g2_at), 64'd64);
        chk("lat_cycles", 64'(lat_n), 64'd2);
        chk("lat_first_t", 64'(lat_first), 64'd260);
        chk("oe_low_cycles", 64'(oe_low), 64'd256);

        n = 0; steps = 0; prev_haddr = hub_addr;
        while (!frame_start && n < 17000) begin
            @(negedge clk); n++;
            if (hub_addr != prev_haddr) begin
                chk("hub_addr_step", 64'(hub_addr), 64'(5'(prev_haddr + 5'd1)));
                steps++;
                prev_haddr = hub_addr;
            end
        end
        chk("frame_period", 64'(cyc - cyc0), 64'd16576);
        chk("hub_addr_steps", 64'(steps), 64'd31);
        chk("hub_addr_last", 64'(hub_addr), 64'd31);
        n = 0;
        while (hub_addr == 5'd31 && n < 600) begin @(negedge clk); n++; end
        chk("hub_addr_wrap", 64'(hub_addr), 64'd0);
        chk("hub_addr_wrap_t", 64'(n), 64'd260);

        wait_f0(5, 6 * ROW_LEN);
        repeat (100) @(negedge clk);
        enable = 1'b0;
        n = 0;
        while (hub_oe_n && n < 600) begin @(negedge clk); n++; end
        oe_low = 0;
        while (!hub_oe_n && oe_low < 600) begin @(negedge clk); oe_low++; end
        chk("row5_display", 64'(oe_low), 64'd256);
        n = 0;
        repeat (40) begin
            if (fb_rd || !hub_oe_n) n++;
            @(negedge clk);
        end
        chk("parked_idle", 64'(n), 64'd0);
        enable = 1'b1;
        @(negedge clk);
        chk("resume_addr_6", 64'({fb_rd, fb_addr}), 64'({1'b1, 6'd6}));
        @(negedge clk);
        chk("resume_addr_38", 64'({fb_rd, fb_addr}), 64'({1'b1, 6'd38}));

        wait_f0(10, 5 * ROW_LEN);
        n = 0;
        while (hub_oe_n && n < 600) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        chk("in_display_row10", 64'(hub_oe_n), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_oe_n", 64'(hub_oe_n), 64'd1);
        chk("midrst_others", 64'(outs & 22'h3ffffd), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_restart_row0", 64'({frame_start, fb_rd, fb_addr}), 64'({2'b11, 6'd0}));

        for (int it = 0; it < 30; it++) begin
            int r = $urandom_range(0, 9);
            if (r == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                rst = 1'b0;
            end
            enable = (r < 7);
            repeat ($urandom_range(1, 1200)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
